// File: rtl/fpmul_pkg.sv
// Shared state encoding and datapath control codes for the FP multiplier control unit.
package fpmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        NORM,
        CHECK,
        RENORM,
        DONE
    } state_t;

    // Bit 8 selects direction (left shift / subtract); the datapath adds the +127 bias itself.
    localparam logic [8:0] SHIFT_L1    = 9'h101;
    localparam logic [8:0] SHIFT_L2    = 9'h102;
    localparam logic [8:0] INCDEC_NOP  = 9'h17F;
    localparam logic [8:0] INCDEC_DEC1 = 9'h101;
    localparam logic [8:0] INCDEC_DEC2 = 9'h102;
    localparam logic [8:0] INCDEC_INC1 = 9'h17E;

    localparam int MUL_LAT_DEFAULT = 1;

endpackage

// File: rtl/fpmul_norm_dec.sv
// Normalization decode: picks shift/exponent codes from the product MSB and flags
// a pre-round fraction that would carry out of the mantissa when rounded up.
module fpmul_norm_dec
    import fpmul_pkg::*;
(
    input  logic [53:0] ula,
    output logic        hi,
    output logic        pre_top_ones,
    output logic [8:0]  shift_code,
    output logic [8:0]  incdec_code
);

    logic [22:0] pre_top;
    logic        unused_low;

    // Bits below the pre-round window only feed the datapath's sticky/round logic.
    assign unused_low = ^ula[28:0];

    always_comb begin
        hi           = ula[53];
        pre_top      = hi ? ula[52:30] : ula[51:29];
        pre_top_ones = &pre_top;
        shift_code   = hi ? SHIFT_L1 : SHIFT_L2;
        incdec_code  = hi ? INCDEC_DEC1 : INCDEC_DEC2;
    end

endmodule

// File: rtl/fpmul_uc.sv
// Control unit for the single-precision FP multiplier: sequences multiply, normalize/round,
// carry-out renormalize and done, and drives the datapath selects as Moore outputs.
module fpmul_uc
    import fpmul_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic [53:0] ula,
    input  logic [25:0] round_fract,
    output logic        sinalMuxFP1,
    output logic        sinalMuxFP2,
    output logic        sinalRound,
    output logic [8:0]  sinalShiftRes,
    output logic [8:0]  sinalIncOrDec,
    output logic        busy,
    output logic        done,
    output logic        force_zero
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_pre_q;
    logic             force_zero_q;
    logic             accept;
    logic             ovf;
    logic             norm_hi;
    logic             pre_top_ones;
    logic [8:0]       norm_shift;
    logic [8:0]       norm_incdec;
    logic             unused_bits;

    fpmul_norm_dec u_norm_dec (
        .ula          (ula),
        .hi           (norm_hi),
        .pre_top_ones (pre_top_ones),
        .shift_code   (norm_shift),
        .incdec_code  (norm_incdec)
    );

    assign unused_bits = ^{norm_hi, round_fract[2:0]};

    assign accept = (state_q == IDLE) && start;
    // Rounding carried all the way out only if the fraction was all ones and now reads zero.
    assign ovf    = ovf_pre_q && (round_fract[25:3] == 23'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            ovf_pre_q    <= 1'b0;
            force_zero_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q        <= CNT_W'(MUL_LAT - 1);
                force_zero_q <= (exp_a == 8'd0) || (exp_b == 8'd0);
            end else if ((state_q == MUL) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (state_q == NORM) begin
                ovf_pre_q <= pre_top_ones;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MUL;
            MUL:     if (cnt_q == '0) state_d = NORM;
            NORM:    state_d = CHECK;
            CHECK:   state_d = ovf ? RENORM : DONE;
            RENORM:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Everything outside NORM/RENORM recirculates the datapath result unchanged.
    always_comb begin
        sinalMuxFP1   = 1'b1;
        sinalMuxFP2   = 1'b1;
        sinalRound    = 1'b0;
        sinalShiftRes = SHIFT_L1;
        sinalIncOrDec = INCDEC_NOP;
        case (state_q)
            NORM: begin
                sinalMuxFP1   = 1'b0;
                sinalMuxFP2   = 1'b0;
                sinalRound    = 1'b1;
                sinalShiftRes = norm_shift;
                sinalIncOrDec = norm_incdec;
            end
            RENORM:  sinalIncOrDec = INCDEC_INC1;
            default: ;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign force_zero = force_zero_q;

endmodule

// File: doc/fpmul_uc.md
Name: fpmul_uc

Overview:
Control unit for the single-precision floating-point multiplier datapath; sits directly upstream of it and drives its mux, shift, exponent-adjust and round selects. Sequences one multiply per start pulse: wait for the mantissa multiplier, normalize and round, detect rounding carry-out and renormalize, then flag done. Emits a zero-result flag for zero-exponent operands.

Parameters:
MUL_LAT, 1, mantissa multiplier latency in cycles (>=1); ula is valid MUL_LAT edges after start is accepted.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; state to IDLE immediately
start  in  1  request; accepted only in IDLE; operands held stable by upstream until done
exp_a  in  8  multiplicador[30:23]
exp_b  in  8  multiplicando[30:23]
ula  in  54  mantissa product from datapath
round_fract  in  26  registered rounded fraction from datapath
sinalMuxFP1  out  1  0 = summed exponent, 1 = fed-back exponent
sinalMuxFP2  out  1  0 = product fraction, 1 = fed-back fraction
sinalRound  out  1  1 = round-to-nearest-even on capture
sinalShiftRes  out  9  [8] 1 = left, [7:0] shift amount
sinalIncOrDec  out  9  [8] 1 = subtract, [7:0] amount (datapath adds +127 internally)
busy  out  1  high from start acceptance until DONE exits
done  out  1  one-cycle pulse, result valid
force_zero  out  1  registered; result must be forced to +/-0

Behaviour:
- States: IDLE, MUL, NORM, CHECK, RENORM, DONE. Moore outputs decoded from the state register.
- Control codes (mux1, mux2, round, shift, incdec):
  HOLD = 1, 1, 0, {1,8'd1}, {1,8'd127}. Recirculates round_fract and exponent unchanged; used in IDLE, MUL, CHECK, DONE so the datapath result stays stable between operations.
  NORM_HI (ula[53]=1) = 0, 0, 1, {1,8'd1}, {1,8'd1}.
  NORM_LO (ula[53]=0) = 0, 0, 1, {1,8'd2}, {1,8'd2}.
  RENORM = HOLD with incdec {1,8'd126}, i.e. exponent +1.
- Transitions:
  IDLE to MUL on start; a cycle counter is loaded with MUL_LAT-1.
  MUL to NORM when the counter reaches 0.
  NORM to CHECK unconditionally; the round register captures at this edge.
  CHECK to RENORM if ovf, else to DONE.
  RENORM to DONE.
  DONE to IDLE.
- ovf = (pre-round top 23 bits all ones) AND (round_fract[25:3]==0). Pre-round top 23 = ula[52:30] if ula[53] is 1, else ula[51:29]; it is computed in NORM and registered.
- Latency: start sampled at edge 0; done is high between edges MUL_LAT+2 and MUL_LAT+3 without renorm, one cycle later with renorm.
- busy = (state != IDLE). done = (state == DONE).
- force_zero: loaded at start acceptance with (exp_a==0 or exp_b==0); held until the next accepted start.
- start while busy is ignored, including start asserted during DONE. start held high continuously launches back-to-back operations with one IDLE cycle between them.
- Reset values: state IDLE, counter 0, ovf register 0, force_zero 0; busy 0, done 0; select outputs at the HOLD code.
- Reset asserted mid-operation aborts immediately with no done pulse; datapath contents are undefined afterwards.
- Exponent overflow/underflow, NaN/Inf and denormals (other than zero) are out of scope.

Decomposition:
- Package fpmul_pkg holds:
  - state enum;
  - 9-bit constants SHIFT_L1, SHIFT_L2, INCDEC_NOP (127), INCDEC_DEC1, INCDEC_DEC2, INCDEC_INC1 (126);
  - MUL_LAT default.
- One sub-module, fpmul_norm_dec (combinational), maps ula to {hi, pre_top23_all_ones, shift code, incdec code}.

Test Plan:
- MUL_LAT=1, ula[53]=1, ula[52:30]=23'h0 -> NORM presents shift 9'h101, incdec 9'h101, round 1; done high 3 cycles after start; no RENORM.
- ula[53:52]=2'b01 -> NORM presents shift 9'h102, incdec 9'h102; in IDLE after done, outputs read mux1=1, mux2=1, shift 9'h101, incdec 9'h17F.
- ula[53]=1, ula[52:30] all ones, round_fract=26'h0 in CHECK -> RENORM for one cycle with incdec 9'h17E; done one cycle later (edge 4 with MUL_LAT=1).
- Same ula, round_fract=26'h3FFFFF8 -> no RENORM.
- exp_a=8'h00, exp_b=8'h80 -> force_zero=1 at done; next start with exp_a=8'h7F, exp_b=8'h7F clears it.
- MUL_LAT=3, reset driven low two cycles into MUL -> busy=0 and outputs at the HOLD code asynchronously; no done; a start after release completes normally.
- start pulsed during MUL and during DONE -> ignored; exactly one done per accepted start.
